// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates a CPU and an I/O requester onto one single-port
// data memory. Every request is granted with a one-cycle pulse; reads return data
// two cycles after the grant through a shared rdata register, and addresses at or
// beyond MEMORY_DEPTH are granted with an err pulse and never reach the memory.
// Build option: define ARB_CPU_PRIORITY_EN for fixed CPU-first arbitration;
// without it, simultaneous requests are resolved round-robin.
module data_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  io_req,
  input  logic                  cpu_we,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  cpu_gnt,
  output logic                  io_gnt,
  output logic                  cpu_rvalid,
  output logic                  io_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT} state_t;

  // One extra bit so that MEMORY_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEMORY_DEPTH);

  state_t r_state, w_state_next;

  // Latched access (winner, type, range flag) and arbitration history.
  logic                  r_sel_io, r_we, r_oor, r_last_io;
  logic                  w_sel_io_next, w_we_next, w_oor_next, w_last_io_next;

  // Registered outputs.
  logic                  r_cpu_gnt, r_io_gnt, r_cpu_rvalid, r_io_rvalid, r_err;
  logic                  r_mem_we, r_mem_re;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, r_rdata;
  logic                  w_cpu_gnt_next, w_io_gnt_next, w_cpu_rvalid_next, w_io_rvalid_next;
  logic                  w_err_next, w_mem_we_next, w_mem_re_next;
  logic [ADDR_WIDTH-1:0] w_mem_addr_next;
  logic [DATA_WIDTH-1:0] w_mem_wdata_next, w_rdata_next;

  // Arbitration result for the current cycle.
  logic                  w_any_req, w_win_io, w_win_we, w_win_oor;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_wdata;

  // Pick the winner among the active requests and select its access fields.
  always_comb begin
    w_any_req = cpu_req | io_req;
`ifdef ARB_CPU_PRIORITY_EN
    w_win_io  = ~cpu_req;
`else
    // On a tie the I/O side wins only if the CPU was granted last.
    w_win_io  = io_req & (~cpu_req | ~r_last_io);
`endif
    w_win_we    = w_win_io ? io_we    : cpu_we;
    w_win_addr  = w_win_io ? io_addr  : cpu_addr;
    w_win_wdata = w_win_io ? io_wdata : cpu_wdata;
    w_win_oor   = ({1'b0, w_win_addr} >= DEPTH_LIMIT);
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: only an in-range read waits for memory data.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any_req) w_state_next = S_ISSUE;
      S_ISSUE:  w_state_next = (!r_we && !r_oor) ? S_RDWAIT : S_IDLE;
      S_RDWAIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and the request latch.
  always_comb begin
    w_cpu_gnt_next    = 1'b0;
    w_io_gnt_next     = 1'b0;
    w_cpu_rvalid_next = 1'b0;
    w_io_rvalid_next  = 1'b0;
    w_err_next        = 1'b0;
    w_mem_we_next     = 1'b0;
    w_mem_re_next     = 1'b0;
    w_sel_io_next     = r_sel_io;
    w_we_next         = r_we;
    w_oor_next        = r_oor;
    w_last_io_next    = r_last_io;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_rdata_next      = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          // Grant, memory strobe and err all appear during the ISSUE cycle.
          w_sel_io_next    = w_win_io;
          w_we_next        = w_win_we;
          w_oor_next       = w_win_oor;
          w_last_io_next   = w_win_io;
          w_mem_addr_next  = w_win_addr;
          w_mem_wdata_next = w_win_wdata;
          w_cpu_gnt_next   = ~w_win_io;
          w_io_gnt_next    = w_win_io;
          w_err_next       = w_win_oor;
          w_mem_we_next    = w_win_we & ~w_win_oor;
          w_mem_re_next    = ~w_win_we & ~w_win_oor;
        end
      end
      S_RDWAIT: begin
        w_rdata_next      = mem_rdata;
        w_cpu_rvalid_next = ~r_sel_io;
        w_io_rvalid_next  = r_sel_io;
      end
      default: ;
    endcase
  end

  // Output and latch registers; the CPU is made to look like it lost last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_gnt    <= 1'b0;
      r_io_gnt     <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_io_rvalid  <= 1'b0;
      r_err        <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_sel_io     <= 1'b0;
      r_we         <= 1'b0;
      r_oor        <= 1'b0;
      r_last_io    <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
    end else begin
      r_cpu_gnt    <= w_cpu_gnt_next;
      r_io_gnt     <= w_io_gnt_next;
      r_cpu_rvalid <= w_cpu_rvalid_next;
      r_io_rvalid  <= w_io_rvalid_next;
      r_err        <= w_err_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_re     <= w_mem_re_next;
      r_sel_io     <= w_sel_io_next;
      r_we         <= w_we_next;
      r_oor        <= w_oor_next;
      r_last_io    <= w_last_io_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_rdata      <= w_rdata_next;
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign io_gnt     = r_io_gnt;
  assign cpu_rvalid = r_cpu_rvalid;
  assign io_rvalid  = r_io_rvalid;
  assign err        = r_err;
  assign mem_we     = r_mem_we;
  assign mem_re     = r_mem_re;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign rdata      = r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: scoreboard bench for data_mem_arbiter. Expected accesses are
// planned from a transaction-level model (round-robin or CPU-first over pending
// request counts, plus an associative reference memory) and checked by a monitor.
module tb_data_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, io_req = 1'b0, cpu_we = 1'b0, io_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, io_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, io_wdata = '0;
  logic          cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, err, mem_we, mem_re;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .io_req(io_req), .cpu_we(cpu_we), .io_we(io_we),
    .cpu_addr(cpu_addr), .io_addr(io_addr), .cpu_wdata(cpu_wdata), .io_wdata(io_wdata),
    .cpu_gnt(cpu_gnt), .io_gnt(io_gnt), .cpu_rvalid(cpu_rvalid), .io_rvalid(io_rvalid),
    .rdata(rdata), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return (DW'(a) * 32'h0100_0193) ^ 32'hA500_0000;
  endfunction

  // Memory model: registered read, contents start at init_val.
  bit [DW-1:0] mem [DEPTH];
  bit          written [DEPTH];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[int'(mem_addr) % DEPTH] <= mem_wdata;
      written[int'(mem_addr) % DEPTH] <= 1'b1;
    end
    if (mem_re)
      mem_rdata <= written[int'(mem_addr) % DEPTH] ? mem[int'(mem_addr) % DEPTH]
                                                    : init_val(int'(mem_addr) % DEPTH);
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    bit            io;
    bit            we;
    bit            oor;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            gcyc;
  } exp_t;

  exp_t g_q[$];
  exp_t r_q[$];
  int   cpu_gnt_log[$];
  int   cpu_rv_log[$];
  bit   who_log[$];

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ref_mem [int];
  bit            m_last_io = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
  endtask

  function automatic req_t mk_req(input logic we, input int a, input logic [DW-1:0] d);
    req_t r;
    r.we = we;
    r.addr = AW'(a);
    r.wdata = d;
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_read(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Grant order for c/i outstanding requests from each side.
  task automatic plan_round(input int c_cnt, input int i_cnt, input req_t cr, input req_t ir);
    int c = c_cnt;
    int i = i_cnt;
    bit w;
    exp_t e;
    req_t r;
    while (c + i > 0) begin
      if (c > 0 && i > 0) begin
`ifdef ARB_CPU_PRIORITY_EN
        w = 1'b0;
`else
        w = m_last_io ? 1'b0 : 1'b1;
`endif
      end else begin
        w = (i > 0);
      end
      r = w ? ir : cr;
      if (w) i--; else c--;
      e.io = w;
      e.we = r.we;
      e.addr = r.addr;
      e.wdata = r.wdata;
      e.oor = (int'(r.addr) >= DEPTH);
      e.rdata = '0;
      e.gcyc = 0;
      if (!e.oor) begin
        if (r.we) ref_mem[int'(r.addr)] = r.wdata;
        else e.rdata = ref_read(int'(r.addr));
      end
      g_q.push_back(e);
      m_last_io = w;
    end
  endtask

  // Hold one requester's request until it has collected n grants.
  task automatic drive_req(input bit io, input req_t r, input int n);
    int got = 0;
    int t = 0;
    if (io) begin io_req = 1'b1; io_we = r.we; io_addr = r.addr; io_wdata = r.wdata; end
    else    begin cpu_req = 1'b1; cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.wdata; end
    while (got < n && t < 100) begin
      @(negedge clk);
      t++;
      if ((io ? io_gnt : cpu_gnt) === 1'b1) got++;
    end
    chk(io ? "io_grant_count" : "cpu_grant_count", got, n);
    @(posedge clk); #1;
    if (io) io_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((g_q.size() + r_q.size()) != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain", g_q.size() + r_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_round(input int c_cnt, input int i_cnt, input req_t cr, input req_t ir);
    plan_round(c_cnt, i_cnt, cr, ir);
    fork
      begin if (c_cnt > 0) drive_req(1'b0, cr, c_cnt); end
      begin if (i_cnt > 0) drive_req(1'b1, ir, i_cnt); end
    join
    wait_drain();
  endtask

  // Monitor: compare every grant and read return against the scoreboard.
  exp_t          mon_e;
  logic [DW-1:0] rd_hold = '0;
  always @(negedge clk) begin
    if (!reset) begin
      g_q.delete();
      r_q.delete();
      rd_hold = '0;
    end else begin
      if (cpu_gnt || io_gnt) begin
        if (cpu_gnt && io_gnt) flag("double_gnt");
        if (cpu_gnt) cpu_gnt_log.push_back(cyc);
        who_log.push_back(io_gnt);
        if (g_q.size() == 0) flag("unexpected_gnt");
        else begin
          mon_e = g_q.pop_front();
          chk("gnt_io", io_gnt, mon_e.io);
          chk("err", err, mon_e.oor);
          chk("mem_we", mem_we, mon_e.we && !mon_e.oor);
          chk("mem_re", mem_re, !mon_e.we && !mon_e.oor);
          if (!mon_e.oor) chk("mem_addr", mem_addr, mon_e.addr);
          if (mon_e.we && !mon_e.oor) chk("mem_wdata", mem_wdata, mon_e.wdata);
          if (!mon_e.we && !mon_e.oor) begin
            mon_e.gcyc = cyc;
            r_q.push_back(mon_e);
          end
        end
      end else begin
        chk("idle_err", err, 1'b0);
        chk("idle_mem_we", mem_we, 1'b0);
        chk("idle_mem_re", mem_re, 1'b0);
      end
      if (cpu_rvalid || io_rvalid) begin
        if (cpu_rvalid && io_rvalid) flag("double_rvalid");
        if (cpu_rvalid) cpu_rv_log.push_back(cyc);
        if (r_q.size() == 0) flag("unexpected_rvalid");
        else begin
          mon_e = r_q.pop_front();
          chk("rvalid_io", io_rvalid, mon_e.io);
          chk("rdata", rdata, mon_e.rdata);
          chk("rvalid_latency", cyc, mon_e.gcyc + 2);
          rd_hold = mon_e.rdata;
        end
      end else begin
        chk("rdata_hold", rdata, rd_hold);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int cnt;
    int c_cnt;
    int i_cnt;
    int t;
    req_t cr;
    req_t ir;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {cpu_gnt, io_gnt}, 2'b00);
    chk("rst_rvalid", {cpu_rvalid, io_rvalid}, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_strobes", {mem_we, mem_re}, 2'b00);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", rdata, '0);

    // First access after reset: CPU read of address 5
    @(posedge clk); #1;
    reset = 1'b1;
    n0 = cyc;
    cpu_gnt_log.delete();
    cpu_rv_log.delete();
    run_round(1, 0, mk_req(1'b0, 5, '0), mk_req(1'b0, 0, '0));
    chk("first_gnt_cycle", cpu_gnt_log.size() > 0 ? cpu_gnt_log[0] : -1, n0 + 1);
    chk("first_rvalid_cycle", cpu_rv_log.size() > 0 ? cpu_rv_log[0] : -1, n0 + 3);
    chk("first_rdata", rdata, 32'hDEADBEEF);

    // I/O write so the CPU is next on a tie, then both held: CPU twice, I/O once
    run_round(0, 1, mk_req(1'b0, 0, '0), mk_req(1'b1, 3, 32'h33));
    who_log.delete();
    run_round(2, 1, mk_req(1'b1, 1, 32'h11), mk_req(1'b1, 2, 32'h22));
    chk("tie_grants", who_log.size(), 3);
`ifdef ARB_CPU_PRIORITY_EN
    chk("tie_order", {who_log.size() > 0 ? who_log[0] : 1'bx, who_log.size() > 1 ? who_log[1] : 1'bx,
                      who_log.size() > 2 ? who_log[2] : 1'bx}, 3'b001);
`else
    chk("tie_order", {who_log.size() > 0 ? who_log[0] : 1'bx, who_log.size() > 1 ? who_log[1] : 1'bx,
                      who_log.size() > 2 ? who_log[2] : 1'bx}, 3'b010);
`endif

    // Out-of-range I/O read
    run_round(0, 1, mk_req(1'b0, 0, '0), mk_req(1'b0, DEPTH, '0));

    // Back-to-back CPU write then read of the same word
    n0 = cyc;
    cpu_gnt_log.delete();
    cpu_rv_log.delete();
    plan_round(1, 0, mk_req(1'b1, 7, 32'hCAFE0007), mk_req(1'b0, 0, '0));
    drive_req(1'b0, mk_req(1'b1, 7, 32'hCAFE0007), 1);
    plan_round(1, 0, mk_req(1'b0, 7, '0), mk_req(1'b0, 0, '0));
    drive_req(1'b0, mk_req(1'b0, 7, '0), 1);
    wait_drain();
    chk("b2b_wr_gnt", cpu_gnt_log.size() > 0 ? cpu_gnt_log[0] : -1, n0 + 1);
    chk("b2b_rd_gnt", cpu_gnt_log.size() > 1 ? cpu_gnt_log[1] : -1, n0 + 3);
    chk("b2b_rvalid", cpu_rv_log.size() > 0 ? cpu_rv_log[0] : -1, n0 + 5);

    // Reset while a CPU read waits for memory data
    plan_round(1, 0, mk_req(1'b0, 9, '0), mk_req(1'b0, 0, '0));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(9);
    t = 0;
    do begin @(negedge clk); t++; end while (cpu_gnt !== 1'b1 && t < 20);
    chk("rst_mid_gnt_seen", cpu_gnt, 1'b1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_strobes", {mem_re, mem_we, cpu_gnt, io_gnt}, 4'b0000);
    chk("rst_mid_rvalid", {cpu_rvalid, io_rvalid}, 2'b00);
    chk("rst_mid_rdata", rdata, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_last_io = 1'b1;
    cnt = 0;
    repeat (8) begin @(negedge clk); if (cpu_rvalid || cpu_gnt) cnt++; end
    chk("rst_mid_no_response", cnt, 0);
    @(posedge clk); #1;

    // Randomized rounds
    for (int k = 0; k < 60; k++) begin
      c_cnt = $urandom_range(0, 2);
      i_cnt = $urandom_range(0, 2);
      if (c_cnt + i_cnt == 0) c_cnt = 1;
      cr = mk_req(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, (1 << AW) - 1) : $urandom_range(0, 15),
                  $urandom);
      ir = mk_req(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, (1 << AW) - 1) : $urandom_range(0, 15),
                  $urandom);
      run_round(c_cnt, i_cnt, cr, ir);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    chk("final_queues", g_q.size() + r_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the word-address width.
REQ-003 Parameter MEMORY_DEPTH, default 1024, SHALL set the number of valid word addresses.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 cpu_req, io_req  input  1 each  SHALL be the access requests from requester 0 (CPU) and requester 1 (I/O).
REQ-007 cpu_we, io_we  input  1 each  SHALL select the access type: 1 = write, 0 = read.
REQ-008 cpu_addr, io_addr  input  ADDR_WIDTH each  SHALL be the word addresses.
REQ-009 cpu_wdata, io_wdata  input  DATA_WIDTH each  SHALL be the write data.
REQ-010 cpu_gnt, io_gnt  output  1 each  SHALL be the one-cycle acceptance pulses.
REQ-011 cpu_rvalid, io_rvalid  output  1 each  SHALL be the one-cycle read-data-valid pulses.
REQ-012 rdata  output  DATA_WIDTH  SHALL be the read data, shared by both requesters.
REQ-013 err  output  1  SHALL be a one-cycle pulse flagging an out-of-range address.
REQ-014 mem_addr, mem_wdata, mem_we, mem_re  output  ADDR_WIDTH/DATA_WIDTH/1/1  SHALL drive the single-port data memory.
REQ-015 mem_rdata  input  DATA_WIDTH  SHALL be the memory read data, valid the cycle after mem_re.

Function
REQ-016 The FSM SHALL have three states, IDLE, ISSUE and RDWAIT; all outputs SHALL be registered.
REQ-017 In IDLE with at least one req high, the FSM SHALL latch the winner's we/addr/wdata and go to ISSUE; with no req it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: on a simultaneous request, the requester not granted last wins; the last-granted pointer SHALL update only on a grant.
REQ-019 In ISSUE, the winner's gnt SHALL be high for exactly that cycle, and mem_addr/mem_wdata SHALL come from the latch.
REQ-020 In ISSUE with an in-range write, mem_we SHALL be high, and the next state SHALL be IDLE.
REQ-021 In ISSUE with an in-range read, mem_re SHALL be high, and the next state SHALL be RDWAIT.
REQ-022 On leaving RDWAIT, rdata SHALL register mem_rdata, the winner's rvalid SHALL pulse high for one cycle, and the next state SHALL be IDLE.
REQ-023 An address >= MEMORY_DEPTH SHALL still produce gnt, SHALL keep mem_we/mem_re low, SHALL pulse err together with gnt, and SHALL produce no rvalid.
REQ-024 Latency: req sampled in cycle N gives gnt in N+1; a read gives rvalid in N+3; after a write, a new request can be sampled in N+2, and after a read, in N+3.
REQ-025 Requesters SHALL hold req/we/addr/wdata stable until gnt; req deasserted before grant SHALL be ignored without error.
REQ-026 A requester whose req stays high after gnt SHALL be treated as a new request.
REQ-027 rdata SHALL hold its last value until the next rvalid.

Reset
REQ-028 When reset is low, the FSM SHALL immediately enter IDLE, and gnt, rvalid, err, mem_we and mem_re SHALL be 0.
REQ-029 When reset is low, mem_addr, mem_wdata and rdata SHALL be 0, and the last-granted pointer SHALL be set so the CPU wins the first tie.
REQ-030 Reset mid-transaction SHALL discard the pending access; no gnt or rvalid SHALL follow for it.

Configuration
REQ-031 With macro ARB_CPU_PRIORITY_EN defined, arbitration SHALL be fixed priority, with the CPU always winning a tie; otherwise REQ-018 SHALL apply.

Verification
REQ-032 Reset release, cpu_req=1, cpu_we=0, cpu_addr=5, mem_rdata=0xDEADBEEF -> cpu_gnt 1 cycle later, mem_re=1 with mem_addr=5, cpu_rvalid 2 cycles after gnt with rdata=0xDEADBEEF.
REQ-033 cpu_req and io_req held high, both writes (addr 1/2, data 0x11/0x22), round-robin -> grants alternate CPU, IO, CPU; mem_we pulses carry 1/0x11 then 2/0x22; with ARB_CPU_PRIORITY_EN -> CPU granted every time.
REQ-034 io_req read at addr 1024 (MEMORY_DEPTH=1024) -> io_gnt and err pulse together, mem_re stays 0, no io_rvalid.
REQ-035 reset driven low in RDWAIT of a CPU read -> mem_re/gnt/rvalid immediately 0; after release no cpu_rvalid without a new request.
REQ-036 Back-to-back CPU write then read -> write gnt at N+1, read sampled at N+2, read gnt at N+3, cpu_rvalid at N+5.
